// File: rtl/sap_run_ctrl.sv
// SAP-1 run controller: reset sequencing, budgeted run, halt/timeout detect, out_reg change log FIFO.
// Latency: one cycle per state step; the log is show-ahead with log_ready popping the head; pushes into a full FIFO without a pop are dropped. Define SAP_RUN_CTRL_CYCLE_STAMP_EN to store cycle stamps.
module sap_run_ctrl #(
  parameter int RESET_CYCLES = 1,
  parameter int MAX_CYCLES   = 50000,
  parameter int CNT_W        = 16,
  parameter int OUT_W        = 8,
  parameter int LOG_DEPTH    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halted,
  input  logic [OUT_W-1:0] out_reg,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic             log_valid,
  output logic [OUT_W-1:0] log_data,
  output logic [CNT_W-1:0] log_cycle,
  input  logic             log_ready,
  output logic             log_overflow
);

  localparam int PW = $clog2(LOG_DEPTH);
  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RW-1:0]    RST_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CYCLES);
  localparam logic [PW:0]      OCC_FULL = (PW + 1)'(LOG_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [RW-1:0]    rst_cnt;
  logic             first_run;
  logic [OUT_W-1:0] last_val;
  logic             start_ok;

  logic [OUT_W-1:0] mem [LOG_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      occ;
  logic             push, pop, full, push_ok;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_RST;
      S_RST:          if (rst_cnt == RST_LAST) state_nxt = S_RUN;
      S_RUN:          if (halted || cycle_count == CNT_LAST) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_reset = (state == S_RST);
    running   = (state == S_RUN);
    done      = (state == S_DONE);
  end

  assign start_ok = start && (state == S_IDLE || state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      rst_cnt     <= '0;
      cycle_count <= '0;
      timeout     <= 1'b0;
      first_run   <= 1'b0;
      last_val    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            rst_cnt     <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
          end
        end
        S_RST: begin
          rst_cnt   <= rst_cnt + 1'b1;
          first_run <= 1'b1;
        end
        S_RUN: begin
          first_run <= 1'b0;
          last_val  <= out_reg;
          // Halt has priority over budget expiry; the count freezes on halt.
          if (!halted) begin
            if (cycle_count == CNT_LAST) begin
              timeout     <= 1'b1;
              cycle_count <= CNT_MAX;
            end else begin
              cycle_count <= cycle_count + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign push    = running && (first_run || out_reg != last_val);
  assign log_valid = (occ != '0);
  assign pop     = log_valid && log_ready;
  assign full    = (occ == OCC_FULL);
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      log_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (start_ok)                  log_overflow <= 1'b0;
      else if (push && full && !pop) log_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= out_reg;
  end

  assign log_data = log_valid ? mem[rd_ptr] : '0;

`ifdef SAP_RUN_CTRL_CYCLE_STAMP_EN
  logic [CNT_W-1:0] stamp_mem [LOG_DEPTH];

  always_ff @(posedge clk) begin
    if (push_ok) stamp_mem[wr_ptr] <= cycle_count;
  end

  assign log_cycle = log_valid ? stamp_mem[rd_ptr] : '0;
`else
  assign log_cycle = '0;
`endif

endmodule

// File: tb/tb_sap_run_ctrl.sv
// Directed bench for sap_run_ctrl: vector table for reset/run/halt/drain, then hand-written corner sequences.
module tb_sap_run_ctrl;

  localparam int RC = 3;
  localparam int MC = 10;
  localparam int CW = 16;
  localparam int OW = 8;
  localparam int LD = 4;

  logic          clk = 1'b0;
  logic          reset, start, halted, log_ready;
  logic [OW-1:0] out_reg;
  logic          cpu_reset, running, done, timeout, log_valid, log_overflow;
  logic [CW-1:0] cycle_count, log_cycle;
  logic [OW-1:0] log_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sap_run_ctrl #(
    .RESET_CYCLES(RC), .MAX_CYCLES(MC), .CNT_W(CW), .OUT_W(OW), .LOG_DEPTH(LD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .halted(halted), .out_reg(out_reg),
    .cpu_reset(cpu_reset), .running(running), .done(done), .timeout(timeout),
    .cycle_count(cycle_count), .log_valid(log_valid), .log_data(log_data),
    .log_cycle(log_cycle), .log_ready(log_ready), .log_overflow(log_overflow)
  );

  typedef struct {
    logic          rst, st, hlt, rdy;
    logic [OW-1:0] o;
    logic          cr, run, dn, to;
    int            cnt;
    logic          vld;
    logic [OW-1:0] dat;
    int            stp;
  } vec_t;

  function automatic vec_t mk(input logic rst, st, hlt, rdy, input logic [OW-1:0] o,
                              input logic cr, run, dn, to, input int cnt,
                              input logic vld, input logic [OW-1:0] dat, input int stp);
    vec_t v;
    v.rst = rst; v.st = st; v.hlt = hlt; v.rdy = rdy; v.o = o;
    v.cr = cr; v.run = run; v.dn = dn; v.to = to; v.cnt = cnt;
    v.vld = vld; v.dat = dat; v.stp = stp;
    return v;
  endfunction

  function automatic logic [CW-1:0] stamp(input int s);
`ifdef SAP_RUN_CTRL_CYCLE_STAMP_EN
    return CW'(s);
`else
    return (s == s) ? '0 : '1;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues start and follows the reset phase until running rises (bounded).
  task automatic run_start();
    int hi;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_cpu_reset", cpu_reset, 1);
    chk("start_done_clr", done, 0);
    chk("start_timeout_clr", timeout, 0);
    chk("start_ovf_clr", log_overflow, 0);
    chk("start_cnt_clr", cycle_count, 0);
    hi = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (running) break;
      if (cpu_reset) hi++;
    end
    chk("rst_len", hi, RC);
    chk("run_entered", running, 1);
    chk("run_cnt0", cycle_count, 0);
    chk("run_cpu_reset0", cpu_reset, 0);
  endtask

  task automatic drain_one(input string name, input logic [OW-1:0] exp_d, input int exp_s);
    chk({name, "_vld"}, log_valid, 1);
    chk({name, "_dat"}, log_data, exp_d);
    chk({name, "_stamp"}, log_cycle, stamp(exp_s));
    log_ready = 1'b1;
    tick();
    log_ready = 1'b0;
  endtask

  vec_t vt[14];

  initial begin
    reset = 1'b1; start = 1'b0; halted = 1'b0; log_ready = 1'b0; out_reg = '0;

    //        rst st hlt rdy out  cr run dn to cnt vld dat stp
    vt[0]  = mk(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0);
    vt[2]  = mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0);
    vt[3]  = mk(0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0);
    vt[4]  = mk(0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0);
    vt[5]  = mk(0, 0, 0, 0, 0,   0, 1, 0, 0, 1, 1, 0, 0);
    vt[6]  = mk(0, 0, 0, 0, 0,   0, 1, 0, 0, 2, 1, 0, 0);
    vt[7]  = mk(0, 0, 0, 0, 5,   0, 1, 0, 0, 3, 1, 0, 0);
    vt[8]  = mk(0, 1, 0, 0, 5,   0, 1, 0, 0, 4, 1, 0, 0);
    vt[9]  = mk(0, 0, 1, 0, 9,   0, 0, 1, 0, 4, 1, 0, 0);
    vt[10] = mk(0, 0, 0, 1, 9,   0, 0, 1, 0, 4, 1, 5, 2);
    vt[11] = mk(0, 0, 0, 1, 9,   0, 0, 1, 0, 4, 1, 9, 4);
    vt[12] = mk(0, 0, 0, 1, 9,   0, 0, 1, 0, 4, 0, 0, 0);
    vt[13] = mk(0, 0, 0, 1, 9,   0, 0, 1, 0, 4, 0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      reset = vt[i].rst; start = vt[i].st; halted = vt[i].hlt;
      log_ready = vt[i].rdy; out_reg = vt[i].o;
      tick();
      chk($sformatf("v%0d_cpu_reset", i), cpu_reset, vt[i].cr);
      chk($sformatf("v%0d_running", i), running, vt[i].run);
      chk($sformatf("v%0d_done", i), done, vt[i].dn);
      chk($sformatf("v%0d_timeout", i), timeout, vt[i].to);
      chk($sformatf("v%0d_cycle_count", i), cycle_count, vt[i].cnt);
      chk($sformatf("v%0d_log_valid", i), log_valid, vt[i].vld);
      chk($sformatf("v%0d_log_data", i), log_data, vt[i].dat);
      chk($sformatf("v%0d_log_cycle", i), log_cycle, stamp(vt[i].stp));
      chk($sformatf("v%0d_overflow", i), log_overflow, 0);
    end
    reset = 1'b0; start = 1'b0; halted = 1'b0; log_ready = 1'b0;

    // Budget timeout: ten RUN cycles without halt.
    out_reg = 8'd7;
    run_start();
    repeat (MC - 1) tick();
    chk("to_pre_running", running, 1);
    chk("to_pre_cnt", cycle_count, MC - 1);
    tick();
    chk("to_done", done, 1);
    chk("to_timeout", timeout, 1);
    chk("to_cnt", cycle_count, MC);
    chk("to_running", running, 0);
    drain_one("to_log", 8'd7, 0);
    chk("to_empty", log_valid, 0);

    // Halt lands on the budget cycle: halt wins.
    run_start();
    repeat (MC - 1) tick();
    halted = 1'b1;
    tick();
    halted = 1'b0;
    chk("hb_done", done, 1);
    chk("hb_timeout", timeout, 0);
    chk("hb_cnt", cycle_count, MC - 1);
    drain_one("hb_log", 8'd7, 0);

    // Fill, push+pop when full, then drop on full.
    run_start();
    for (int v = 1; v <= 4; v++) begin
      out_reg = OW'(v);
      tick();
    end
    chk("ov_full_noflag", log_overflow, 0);
    out_reg = 8'd5; log_ready = 1'b1;
    tick();
    chk("ov_pushpop_noflag", log_overflow, 0);
    out_reg = 8'd6; log_ready = 1'b0; halted = 1'b1;
    tick();
    halted = 1'b0;
    chk("ov_flag", log_overflow, 1);
    chk("ov_done", done, 1);
    for (int v = 2; v <= 5; v++) drain_one($sformatf("ov_e%0d", v), OW'(v), v - 1);
    chk("ov_empty", log_valid, 0);
    chk("ov_sticky", log_overflow, 1);

    // Same six values with log_ready held: every entry streams through.
    log_ready = 1'b1;
    run_start();
    for (int v = 1; v <= 6; v++) begin
      out_reg = OW'(10 + v);
      halted = (v == 6);
      tick();
      chk($sformatf("st_vld%0d", v), log_valid, 1);
      chk($sformatf("st_dat%0d", v), log_data, 10 + v);
    end
    halted = 1'b0;
    tick();
    chk("st_empty", log_valid, 0);
    chk("st_noflag", log_overflow, 0);
    log_ready = 1'b0;

    // Reset mid-run aborts and clears everything.
    run_start();
    out_reg = 8'd3;
    tick();
    out_reg = 8'd4; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_cpu_reset", cpu_reset, 0);
    chk("mr_running", running, 0);
    chk("mr_done", done, 0);
    chk("mr_timeout", timeout, 0);
    chk("mr_cnt", cycle_count, 0);
    chk("mr_vld", log_valid, 0);
    chk("mr_dat", log_data, 0);
    chk("mr_stamp", log_cycle, 0);
    chk("mr_ovf", log_overflow, 0);
    out_reg = 8'd8;
    tick();
    chk("mr_idle_nopush", log_valid, 0);
    run_start();
    halted = 1'b1;
    tick();
    halted = 1'b0;
    chk("mr2_done", done, 1);
    chk("mr2_cnt", cycle_count, 0);
    drain_one("mr2_log", 8'd8, 0);
    chk("mr2_empty", log_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sap_run_ctrl.md
Name: sap_run_ctrl

Overview:
Synthesizable run controller for the SAP-1 machine. It sequences the machine's reset, runs it under a cycle budget, detects halt or timeout, and logs every change of the output register into a small FIFO for a host or bench to drain. It is the parametrised, hardware-resident successor of the bench-level reset/run/monitor loop, and sits between a host interface and `machine`.

Parameters:
- RESET_CYCLES, 1, number of cycles `cpu_reset` is held high per run (≥1).
- MAX_CYCLES, 50000, cycle budget per run before timeout (≥1).
- CNT_W, 16, width of `cycle_count`; must hold MAX_CYCLES.
- OUT_W, 8, width of the monitored output register.
- LOG_DEPTH, 8, FIFO entries (power of two, ≥2).

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle run request
- `halted`  in  1  machine halt flag
- `out_reg`  in  OUT_W  machine output register
- `cpu_reset`  out  1  reset to machine
- `running`  out  1  high in RUN
- `done`  out  1  run finished (sticky until next start)
- `timeout`  out  1  run ended by budget (sticky until next start)
- `cycle_count`  out  CNT_W  cycles spent in RUN
- `log_valid`  out  1  FIFO non-empty
- `log_data`  out  OUT_W  FIFO head value (show-ahead)
- `log_cycle`  out  CNT_W  FIFO head cycle stamp (see optional feature)
- `log_ready`  in  1  pop head when `log_valid` is high
- `log_overflow`  out  1  sticky: an entry was dropped

Behaviour:
- **Reset (`reset`=1 at posedge):**
  - State IDLE; `cpu_reset`=0, `running`=0, `done`=0, `timeout`=0, `cycle_count`=0.
  - FIFO emptied; `log_valid`=0, `log_data`=0, `log_cycle`=0, `log_overflow`=0.
  - Reset mid-run aborts immediately, with no further log pushes.
- **States:** IDLE, RST, RUN, DONE.
- **IDLE:** `start` → RST on the next cycle. `cpu_reset` goes high in the same edge.
  - Also cleared on this edge: `done`, `timeout`, `log_overflow`, `cycle_count`, reset-cycle counter.
  - The FIFO is not cleared.
- **RST:** `cpu_reset`=1 for exactly RESET_CYCLES cycles, then → RUN with `cpu_reset`=0. `start` is ignored.
- **RUN:** `running`=1. Each cycle evaluates, in priority order:
  1. `halted`=1 → DONE; `cycle_count` holds.
  2. Else if `cycle_count`==MAX_CYCLES-1 → DONE; `timeout`←1; `cycle_count`←MAX_CYCLES.
  3. Else `cycle_count`++.
  - Halt and budget expiry in the same cycle: halt wins, `timeout`=0.
- **DONE:** `done`=1, `running`=0, `cpu_reset`=0. `start` behaves as in IDLE, starting a new run.
- **`start` in RST or RUN:** ignored.
- **Output logging (RUN only):**
  - The first RUN cycle always pushes the current `out_reg`.
  - Each later RUN cycle pushes if `out_reg` ≠ the last-sampled value.
  - Sampling uses the value present in that cycle; the halt cycle is still evaluated for a push.
- **FIFO:**
  - Head visible combinationally on `log_data`/`log_cycle` while `log_valid`=1.
  - Pop occurs when `log_valid` & `log_ready` at posedge.
  - Push with FIFO full and no pop: entry dropped, `log_overflow`←1.
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Pop while empty: ignored.
  - Pointers wrap modulo LOG_DEPTH; an occupancy counter of log2(LOG_DEPTH)+1 bits distinguishes full from empty.

Optional Feature:
- Macro: `SAP_RUN_CTRL_CYCLE_STAMP_EN`.
- **Defined:** each FIFO entry also stores the `cycle_count` value at push time; `log_cycle` presents it for the head entry.
- **Undefined:** no stamp storage; `log_cycle` is constant 0.
- All other behaviour is identical.

Test Plan:
- Reset, then `start` with RESET_CYCLES=3 → `cpu_reset` high exactly 3 cycles, then `running`=1 and `cycle_count`=0 on first RUN cycle.
- `out_reg` sequence 0,0,5,5,9, then `halted`=1 → FIFO holds 0,5,9; `done`=1, `timeout`=0. With stamps defined, `log_cycle`=0,2,4.
- MAX_CYCLES=10, `halted` never set → DONE after 10 RUN cycles; `timeout`=1, `cycle_count`=10.
- `halted` rises exactly on the budget cycle (`cycle_count`=MAX_CYCLES-1) → `timeout`=0, `done`=1, `cycle_count`=MAX_CYCLES-1.
- LOG_DEPTH=4, 6 distinct `out_reg` values, `log_ready`=0 → 4 entries kept, `log_overflow`=1. Repeat with `log_ready`=1 held → 6 entries drained in order, `log_overflow`=0.
- Assert `reset` mid-RUN → next cycle: IDLE, FIFO empty, all outputs 0. A subsequent `start` runs normally.
